// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if: fetch, loader and RAM-macro signals of the instruction RAM port arbiter.
// Rev 1.0 - initial release.
`default_nettype none

interface imem_port_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  logic              cpu_stall;

  logic              l_req;
  logic              l_we;
  logic [31:0]       l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;
  logic              l_err;
  logic [15:0]       l_count;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, cpu_stall,
    output l_gnt, l_rvalid, l_rdata, l_err, l_count,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters and RAM macro side
  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, cpu_stall,
    input  l_gnt, l_rvalid, l_rdata, l_err, l_count,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the single-port instruction RAM between CPU fetch and a program loader.
// Rev 1.0 - initial release.
`default_nettype none

module imem_port_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  imem_port_arbiter_if.slave   io_bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    LOAD   = 2'd2,
    RESUME = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              w_f_in_range;
  logic              w_l_in_range;
  logic              w_f_gnt;
  logic              w_l_gnt;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_f_rdata;
  logic [DATA_W-1:0] w_l_rdata;
  logic              w_unused_addr_bits;

  logic              r_f_rv;
  logic              r_f_ok;
  logic              r_l_rv;
  logic              r_l_ok;
  logic [DATA_W-1:0] r_f_hold;
  logic [DATA_W-1:0] r_l_hold;
  logic              r_l_err;
  logic [15:0]       r_l_count;

  assign w_f_in_range       = (io_bus.f_addr[31:ADDR_W+2] == '0);
  assign w_l_in_range       = (io_bus.l_addr[31:ADDR_W+2] == '0);
  assign w_unused_addr_bits = ^{io_bus.f_addr[1:0], io_bus.l_addr[1:0]};

  always_comb begin
    w_next      = r_state;
    w_f_gnt     = 1'b0;
    w_l_gnt     = 1'b0;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (r_state)
      RUN: begin
        // The fetch issued alongside a new loader request is still served.
        w_f_gnt  = io_bus.f_req;
        w_mem_en = io_bus.f_req & w_f_in_range;
        if (io_bus.f_req) begin
          w_mem_addr = io_bus.f_addr[ADDR_W+1:2];
        end
        if (io_bus.l_req) begin
          w_next = DRAIN;
        end
      end
      // A fetch read always completes in one cycle, so one drain cycle suffices.
      DRAIN: w_next = LOAD;
      LOAD: begin
        if (io_bus.l_req) begin
          w_l_gnt     = 1'b1;
          w_mem_en    = 1'b1;
          w_mem_we    = io_bus.l_we & w_l_in_range;
          w_mem_addr  = io_bus.l_addr[ADDR_W+1:2];
          w_mem_wdata = io_bus.l_wdata;
        end else begin
          w_next = RESUME;
        end
      end
      RESUME:  w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  // Read data is steered to the issuing requester and held between reads.
  assign w_f_rdata = r_f_rv ? (r_f_ok ? io_bus.mem_rdata : '0) : r_f_hold;
  assign w_l_rdata = r_l_rv ? (r_l_ok ? io_bus.mem_rdata : '0) : r_l_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= RUN;
      r_f_rv    <= 1'b0;
      r_f_ok    <= 1'b0;
      r_l_rv    <= 1'b0;
      r_l_ok    <= 1'b0;
      r_f_hold  <= '0;
      r_l_hold  <= '0;
      r_l_err   <= 1'b0;
      r_l_count <= 16'd0;
    end else begin
      r_state  <= w_next;
      r_f_rv   <= w_f_gnt;
      r_f_ok   <= w_f_in_range;
      r_l_rv   <= w_l_gnt & ~io_bus.l_we;
      r_l_ok   <= w_l_in_range;
      r_f_hold <= w_f_rdata;
      r_l_hold <= w_l_rdata;
      if (w_l_gnt && !w_l_in_range) begin
        r_l_err <= 1'b1;
      end
      if (w_l_gnt && io_bus.l_we && w_l_in_range && (r_l_count != 16'hFFFF)) begin
        r_l_count <= r_l_count + 16'd1;
      end
    end
  end

  // Request-derived outputs are forced low while reset is asserted.
  assign io_bus.f_gnt     = reset_n & w_f_gnt;
  assign io_bus.l_gnt     = reset_n & w_l_gnt;
  assign io_bus.mem_en    = reset_n & w_mem_en;
  assign io_bus.mem_we    = reset_n & w_mem_we;
  assign io_bus.mem_addr  = reset_n ? w_mem_addr : '0;
  assign io_bus.mem_wdata = reset_n ? w_mem_wdata : '0;
  assign io_bus.cpu_stall = (r_state != RUN);
  assign io_bus.f_rvalid  = r_f_rv;
  assign io_bus.f_rdata   = w_f_rdata;
  assign io_bus.l_rvalid  = r_l_rv;
  assign io_bus.l_rdata   = w_l_rdata;
  assign io_bus.l_err     = r_l_err;
  assign io_bus.l_count   = r_l_count;

endmodule

`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: randomized self-checking bench with a RAM macro and a golden memory model.
// Rev 1.0 - initial release.
`default_nettype none

module tb_imem_port_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  imem_port_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  imem_port_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io_bus  (bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] fill_seed;
  logic [31:0] ram  [64];
  logic [31:0] gold [64];
  int unsigned exp_count;
  logic        exp_err;
  logic        f_pend, l_pend;
  logic [31:0] f_pend_exp, f_last, l_pend_exp, l_last;

  function automatic logic [31:0] fill_val(input int i);
    return fill_seed ^ (32'(i) * 32'h9E3779B9);
  endfunction

  // RAM macro: preloaded while reset is held, one-cycle read latency.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) ram[i] <= fill_val(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.f_req = 0; bus.f_addr = 0; bus.l_req = 0; bus.l_we = 0; bus.l_addr = 0; bus.l_wdata = 0;
    reset_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.f_gnt, bus.f_rvalid, bus.f_rdata, bus.cpu_stall, bus.l_gnt, bus.l_rvalid, bus.l_rdata,
         bus.l_err, bus.l_count, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0)
      begin errors++; $display("FAIL reset_outputs: some output nonzero during reset, expected all 0"); end
    reset_n = 1;
    tick();
    @(negedge clk);
    checks++;
    if ({bus.cpu_stall, bus.l_count, bus.l_err, bus.f_rvalid, bus.l_rvalid, bus.f_rdata, bus.l_rdata} !== '0)
      begin errors++; $display("FAIL post_reset_state: stall=%b count=%0d err=%b, expected 0", bus.cpu_stall, bus.l_count, bus.l_err); end
    f_pend = 0; f_last = 0; l_pend = 0; l_last = 0; exp_count = 0; exp_err = 0;
  endtask

  task automatic test_fetch();
    logic [31:0] a;
    logic        req;
    for (int i = 0; i < 16; i++) begin
      tick();
      req = (i < 3) ? 1'b1 : ((i == 15) ? 1'b0 : 1'($urandom_range(0, 1)));
      a   = (i < 3) ? 32'(i * 4) : {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      bus.f_req = req; bus.f_addr = a;
      @(negedge clk);
      checks++;
      if (bus.f_gnt !== req || bus.mem_en !== req || bus.mem_we !== 1'b0 || bus.cpu_stall !== 1'b0)
        begin errors++; $display("FAIL fetch_grant: gnt=%b en=%b we=%b stall=%b, expected gnt=en=%b we=0 stall=0", bus.f_gnt, bus.mem_en, bus.mem_we, bus.cpu_stall, req); end
      if (req) begin
        checks++;
        if (bus.mem_addr !== a[7:2]) begin errors++; $display("FAIL fetch_addr: got %0d expected %0d", bus.mem_addr, a[7:2]); end
      end
      checks++;
      if (bus.f_rvalid !== f_pend) begin errors++; $display("FAIL fetch_rvalid: got %b expected %b", bus.f_rvalid, f_pend); end
      if (f_pend) f_last = f_pend_exp;
      checks++;
      if (bus.f_rdata !== f_last) begin errors++; $display("FAIL fetch_rdata: got %h expected %h", bus.f_rdata, f_last); end
      f_pend = req; f_pend_exp = gold[a[7:2]];
    end
  endtask

  task automatic test_load_session();
    logic [31:0] d;
    logic [31:0] rd_addr [6];
    rd_addr[0] = 32'h44;
    for (int j = 1; j < 6; j++) rd_addr[j] = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    // Fetch and loader request on the same RUN cycle: fetch wins.
    tick();
    bus.f_req = 1; bus.f_addr = 32'h20; bus.l_req = 1; bus.l_we = 1; bus.l_addr = 0; bus.l_wdata = 0;
    @(negedge clk);
    checks++;
    if (bus.f_gnt !== 1'b1 || bus.cpu_stall !== 1'b0 || bus.l_gnt !== 1'b0 || bus.f_rvalid !== 1'b0)
      begin errors++; $display("FAIL same_cycle_req: f_gnt=%b stall=%b l_gnt=%b, expected 1 0 0", bus.f_gnt, bus.cpu_stall, bus.l_gnt); end
    f_pend_exp = gold[8];
    tick();
    @(negedge clk);
    checks++;
    if (bus.cpu_stall !== 1'b1 || bus.f_gnt !== 1'b0 || bus.l_gnt !== 1'b0 || bus.mem_en !== 1'b0)
      begin errors++; $display("FAIL drain_cycle: stall=%b f_gnt=%b l_gnt=%b en=%b, expected 1 0 0 0", bus.cpu_stall, bus.f_gnt, bus.l_gnt, bus.mem_en); end
    checks++;
    if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== f_pend_exp)
      begin errors++; $display("FAIL drain_fetch_return: rvalid=%b rdata=%h, expected 1 %h", bus.f_rvalid, bus.f_rdata, f_pend_exp); end
    f_last = f_pend_exp; f_pend = 0;
    for (int i = 0; i < 23; i++) begin
      tick();
      d = (i == 17) ? 32'hE08FF000 : $urandom;
      bus.l_addr = 32'(i * 4); bus.l_wdata = d;
      @(negedge clk);
      checks++;
      if (bus.l_gnt !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 6'(i) ||
          bus.mem_wdata !== d || bus.f_gnt !== 1'b0 || bus.f_rvalid !== 1'b0 || bus.cpu_stall !== 1'b1)
        begin errors++; $display("FAIL load_write: i=%0d gnt=%b we=%b addr=%0d wdata=%h, expected 1 1 %0d %h", i, bus.l_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata, i, d); end
      gold[i] = d; exp_count++;
    end
    for (int j = 0; j < 7; j++) begin
      tick();
      if (j < 6) begin bus.l_we = 0; bus.l_addr = rd_addr[j]; end
      else bus.l_req = 0;
      @(negedge clk);
      checks++;
      if (bus.l_gnt !== (j < 6) || bus.mem_we !== 1'b0)
        begin errors++; $display("FAIL load_read_gnt: j=%0d gnt=%b we=%b, expected %b 0", j, bus.l_gnt, bus.mem_we, j < 6); end
      checks++;
      if (bus.l_rvalid !== l_pend || bus.f_rvalid !== 1'b0)
        begin errors++; $display("FAIL load_rvalid: j=%0d l_rvalid=%b f_rvalid=%b, expected %b 0", j, bus.l_rvalid, bus.f_rvalid, l_pend); end
      if (l_pend) l_last = l_pend_exp;
      checks++;
      if (bus.l_rdata !== l_last) begin errors++; $display("FAIL load_rdata: j=%0d got %h expected %h", j, bus.l_rdata, l_last); end
      checks++;
      if (bus.l_count !== 16'd23) begin errors++; $display("FAIL load_count: got %0d expected 23", bus.l_count); end
      l_pend = (j < 6); l_pend_exp = (j < 6) ? gold[rd_addr[j][7:2]] : '0;
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.cpu_stall !== 1'b1 || bus.f_gnt !== 1'b0 || bus.l_gnt !== 1'b0 || bus.l_rvalid !== 1'b0)
      begin errors++; $display("FAIL resume_cycle: stall=%b f_gnt=%b l_gnt=%b, expected 1 0 0", bus.cpu_stall, bus.f_gnt, bus.l_gnt); end
    l_pend = 0;
    tick();
    bus.f_addr = 32'h44;
    @(negedge clk);
    checks++;
    if (bus.cpu_stall !== 1'b0 || bus.f_gnt !== 1'b1 || bus.mem_addr !== 6'd17)
      begin errors++; $display("FAIL fetch_resumed: stall=%b gnt=%b addr=%0d, expected 0 1 17", bus.cpu_stall, bus.f_gnt, bus.mem_addr); end
    tick();
    bus.f_req = 0;
    @(negedge clk);
    checks++;
    if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== 32'hE08FF000)
      begin errors++; $display("FAIL fetch_loaded_word: rvalid=%b rdata=%h, expected 1 e08ff000", bus.f_rvalid, bus.f_rdata); end
    f_last = 32'hE08FF000;
  endtask

  task automatic test_range();
    tick();
    bus.f_req = 0; bus.l_req = 1; bus.l_we = 1; bus.l_addr = 32'h100; bus.l_wdata = $urandom;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (bus.l_gnt !== 1'b1 || bus.mem_we !== 1'b0 || bus.l_err !== 1'b0)
      begin errors++; $display("FAIL oor_write: gnt=%b we=%b err=%b, expected 1 0 0", bus.l_gnt, bus.mem_we, bus.l_err); end
    tick();
    bus.l_we = 0;
    @(negedge clk);
    checks++;
    if (bus.l_err !== 1'b1 || bus.l_count !== exp_count[15:0] || bus.l_gnt !== 1'b1)
      begin errors++; $display("FAIL oor_err_set: err=%b count=%0d gnt=%b, expected 1 %0d 1", bus.l_err, bus.l_count, bus.l_gnt, exp_count); end
    exp_err = 1;
    tick();
    bus.l_req = 0;
    @(negedge clk);
    checks++;
    if (bus.l_rvalid !== 1'b1 || bus.l_rdata !== 32'h0 || bus.l_gnt !== 1'b0)
      begin errors++; $display("FAIL oor_read: rvalid=%b rdata=%h gnt=%b, expected 1 0 0", bus.l_rvalid, bus.l_rdata, bus.l_gnt); end
    l_last = 0;
    tick();
    bus.f_req = 1; bus.f_addr = 32'h104;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (bus.f_gnt !== 1'b1 || bus.mem_en !== 1'b0 || bus.cpu_stall !== 1'b0)
      begin errors++; $display("FAIL oor_fetch: gnt=%b en=%b stall=%b, expected 1 0 0", bus.f_gnt, bus.mem_en, bus.cpu_stall); end
    tick();
    bus.f_req = 0;
    @(negedge clk);
    checks++;
    if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== 32'h0 || bus.l_err !== 1'b1)
      begin errors++; $display("FAIL oor_fetch_data: rvalid=%b rdata=%h err=%b, expected 1 0 1", bus.f_rvalid, bus.f_rdata, bus.l_err); end
    f_last = 0; f_pend = 0;
  endtask

  task automatic test_random();
    logic        req, we, inr;
    logic [31:0] a, d;
    int          n, k;
    for (int s = 0; s < 6; s++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        tick();
        req = 1'($urandom_range(0, 1));
        a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 7) == 0) a[31:8] = 24'($urandom_range(1, 32'h00FF_FFFF));
        bus.f_req = req; bus.f_addr = a; bus.l_req = (i == n - 1);
        @(negedge clk);
        checks++;
        if (bus.f_gnt !== req || bus.cpu_stall !== 1'b0 || bus.l_gnt !== 1'b0 || bus.mem_en !== (req && a[31:8] == 0))
          begin errors++; $display("FAIL rnd_run: s=%0d gnt=%b stall=%b en=%b, expected gnt=%b stall=0", s, bus.f_gnt, bus.cpu_stall, bus.mem_en, req); end
        checks++;
        if (bus.f_rvalid !== f_pend) begin errors++; $display("FAIL rnd_f_rvalid: got %b expected %b", bus.f_rvalid, f_pend); end
        if (f_pend) f_last = f_pend_exp;
        checks++;
        if (bus.f_rdata !== f_last) begin errors++; $display("FAIL rnd_f_rdata: got %h expected %h", bus.f_rdata, f_last); end
        f_pend = req; f_pend_exp = (a[31:8] == 0) ? gold[a[7:2]] : '0;
      end
      tick();
      bus.f_req = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (bus.cpu_stall !== 1'b1 || bus.f_gnt !== 1'b0 || bus.l_gnt !== 1'b0 || bus.f_rvalid !== f_pend)
        begin errors++; $display("FAIL rnd_drain: stall=%b f_gnt=%b l_gnt=%b rvalid=%b, expected 1 0 0 %b", bus.cpu_stall, bus.f_gnt, bus.l_gnt, bus.f_rvalid, f_pend); end
      if (f_pend) f_last = f_pend_exp;
      checks++;
      if (bus.f_rdata !== f_last) begin errors++; $display("FAIL rnd_drain_rdata: got %h expected %h", bus.f_rdata, f_last); end
      f_pend = 0;
      k = $urandom_range(1, 10);
      for (int j = 0; j <= k; j++) begin
        tick();
        we = 1'($urandom_range(0, 1));
        a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 7) == 0) a[31:8] = 24'($urandom_range(1, 32'h00FF_FFFF));
        inr = (a[31:8] == 0);
        d = $urandom;
        bus.l_req = (j < k); bus.l_we = we; bus.l_addr = a; bus.l_wdata = d;
        bus.f_req = 1'($urandom_range(0, 1));
        @(negedge clk);
        checks++;
        if (bus.cpu_stall !== 1'b1 || bus.f_gnt !== 1'b0 || bus.f_rvalid !== 1'b0 || bus.l_gnt !== (j < k))
          begin errors++; $display("FAIL rnd_load_gnt: j=%0d stall=%b f_gnt=%b l_gnt=%b, expected 1 0 %b", j, bus.cpu_stall, bus.f_gnt, bus.l_gnt, j < k); end
        if (j < k) begin
          checks++;
          if (bus.mem_we !== (we && inr) || bus.mem_addr !== a[7:2] || (we && bus.mem_wdata !== d))
            begin errors++; $display("FAIL rnd_load_mem: we=%b addr=%0d wdata=%h, expected %b %0d %h", bus.mem_we, bus.mem_addr, bus.mem_wdata, we && inr, a[7:2], d); end
        end
        checks++;
        if (bus.l_rvalid !== l_pend) begin errors++; $display("FAIL rnd_l_rvalid: got %b expected %b", bus.l_rvalid, l_pend); end
        if (l_pend) l_last = l_pend_exp;
        checks++;
        if (bus.l_rdata !== l_last) begin errors++; $display("FAIL rnd_l_rdata: got %h expected %h", bus.l_rdata, l_last); end
        checks++;
        if (bus.l_count !== exp_count[15:0] || bus.l_err !== exp_err)
          begin errors++; $display("FAIL rnd_count_err: count=%0d err=%b, expected %0d %b", bus.l_count, bus.l_err, exp_count, exp_err); end
        l_pend = (j < k) && !we;
        l_pend_exp = inr ? gold[a[7:2]] : '0;
        if (j < k) begin
          if (we && inr) begin
            gold[a[7:2]] = d;
            if (exp_count < 65535) exp_count++;
          end
          if (!inr) exp_err = 1;
        end
      end
      tick();
      bus.l_req = 1'($urandom_range(0, 1));
      bus.f_req = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (bus.cpu_stall !== 1'b1 || bus.f_gnt !== 1'b0 || bus.l_gnt !== 1'b0 || bus.l_rvalid !== 1'b0)
        begin errors++; $display("FAIL rnd_resume: stall=%b f_gnt=%b l_gnt=%b rvalid=%b, expected 1 0 0 0", bus.cpu_stall, bus.f_gnt, bus.l_gnt, bus.l_rvalid); end
      checks++;
      if (bus.l_count !== exp_count[15:0] || bus.l_err !== exp_err)
        begin errors++; $display("FAIL rnd_session_end: count=%0d err=%b, expected %0d %b", bus.l_count, bus.l_err, exp_count, exp_err); end
    end
  endtask

  task automatic test_async_reset();
    tick();
    bus.f_req = 1; bus.f_addr = 0; bus.l_req = 1; bus.l_we = 0; bus.l_addr = 32'h8;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (bus.l_gnt !== 1'b1) begin errors++; $display("FAIL areset_enter_load: l_gnt=%b expected 1", bus.l_gnt); end
    tick();
    checks++;
    if (bus.l_rvalid !== 1'b1) begin errors++; $display("FAIL areset_pending: l_rvalid=%b expected 1", bus.l_rvalid); end
    #2 reset_n = 0;
    #1;
    checks++;
    if ({bus.f_gnt, bus.f_rvalid, bus.f_rdata, bus.cpu_stall, bus.l_gnt, bus.l_rvalid, bus.l_rdata,
         bus.l_err, bus.l_count, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0)
      begin errors++; $display("FAIL areset_outputs: stall=%b l_gnt=%b en=%b count=%0d, expected all 0", bus.cpu_stall, bus.l_gnt, bus.mem_en, bus.l_count); end
    bus.l_req = 0; bus.f_req = 0;
    @(negedge clk);
    reset_n = 1;
    exp_count = 0; exp_err = 0; l_pend = 0; f_pend = 0;
    tick();
    bus.f_req = 1; bus.f_addr = 32'h8;
    @(negedge clk);
    checks++;
    if (bus.cpu_stall !== 1'b0 || bus.f_gnt !== 1'b1 || bus.l_rvalid !== 1'b0 || bus.l_count !== 16'd0 ||
        bus.l_err !== 1'b0 || bus.l_rdata !== 32'h0)
      begin errors++; $display("FAIL areset_run: stall=%b f_gnt=%b l_rvalid=%b count=%0d err=%b, expected 0 1 0 0 0", bus.cpu_stall, bus.f_gnt, bus.l_rvalid, bus.l_count, bus.l_err); end
    tick();
    bus.f_req = 0;
    @(negedge clk);
    checks++;
    if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== gold[2])
      begin errors++; $display("FAIL areset_fetch: rvalid=%b rdata=%h, expected 1 %h", bus.f_rvalid, bus.f_rdata, gold[2]); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_seed = $urandom;
    for (int i = 0; i < 64; i++) gold[i] = fill_val(i);
    test_reset();
    test_fetch();
    test_load_session();
    test_range();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
